// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access pipeline stage that sits right after the execute stage.
// Non-memory instructions pass straight through to write-back with one
// cycle of latency. RV32I loads and stores are run over a req/gnt/rvalid
// data-memory bus, and the front of the pipeline is stalled while a
// transfer is outstanding.
//
// Ports
//   clk_100MHz, reset        : clock, synchronous active-high reset
//   instruction_fetched_R1   : instruction from execute
//   rd_1                     : destination register from execute
//   data_out_exe             : ALU result, or effective address for LOAD/STORE
//   data_rs2_R1              : store source data
//   stall_mem                : holds the upstream stages (combinational)
//   dmem_req/we/addr/wdata/be: data-memory request side
//   dmem_gnt/rvalid/rdata    : data-memory response side
//   data_out_mem, rd_2,
//   reg_write_en,
//   instruction_fetched_R2   : registered write-back outputs
//   misaligned_exc           : one-cycle pulse on a misaligned access
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int         DMEM_AW = 32,
    parameter logic [6:0] R_TYPE  = 7'b0110011,
    parameter logic [6:0] I_TYPE  = 7'b0010011,
    parameter logic [6:0] LOAD    = 7'b0000011,
    parameter logic [6:0] STORE   = 7'b0100011
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic [31:0]        instruction_fetched_R1,
    input  logic [4:0]         rd_1,
    input  logic [31:0]        data_out_exe,
    input  logic [31:0]        data_rs2_R1,
    output logic               stall_mem,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    output logic [3:0]         dmem_be,
    input  logic               dmem_gnt,
    input  logic               dmem_rvalid,
    input  logic [31:0]        dmem_rdata,
    output logic [31:0]        data_out_mem,
    output logic [4:0]         rd_2,
    output logic               reg_write_en,
    output logic [31:0]        instruction_fetched_R2,
    output logic               misaligned_exc
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // ------------------------------------------------------------------
    // Decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [1:0] addr_lo;

    assign opcode  = instruction_fetched_R1[6:0];
    assign funct3  = instruction_fetched_R1[14:12];
    assign addr_lo = data_out_exe[1:0];

    logic is_load;
    logic is_store;
    logic load_f3_ok;
    logic store_f3_ok;
    logic mem_op;
    logic misaligned;
    logic access_ok;

    always_comb begin
        is_load     = (opcode == LOAD);
        is_store    = (opcode == STORE);
        load_f3_ok  = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                      (funct3 == F3_BU) || (funct3 == F3_HU);
        store_f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        mem_op      = (is_load && load_f3_ok) || (is_store && store_f3_ok);
        // funct3[1:0] encodes the access size for every valid load/store
        misaligned  = mem_op &&
                      (((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00)));
        access_ok   = mem_op && !misaligned;
    end

    // Store byte lanes: data is replicated so the addressed lane always
    // carries the right bytes regardless of the offset.
    logic [3:0]  be_store;
    logic [31:0] wdata_store;

    always_comb begin
        be_store    = 4'b1111;
        wdata_store = data_rs2_R1;
        case (funct3[1:0])
            2'b00: begin
                be_store    = 4'b0001 << addr_lo;
                wdata_store = {4{data_rs2_R1[7:0]}};
            end
            2'b01: begin
                be_store    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_store = {2{data_rs2_R1[15:0]}};
            end
            default: begin
                be_store    = 4'b1111;
                wdata_store = data_rs2_R1;
            end
        endcase
    end

    // Word-aligned bus address, fitted to the bus width
    logic [DMEM_AW-1:0] addr_word;

    generate
        if (DMEM_AW <= 32) begin : g_addr_narrow
            assign addr_word = {data_out_exe[DMEM_AW-1:2], 2'b00};
        end else begin : g_addr_wide
            assign addr_word = {{(DMEM_AW-32){1'b0}}, data_out_exe[31:2], 2'b00};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t             state_reg;
    logic               req_reg;
    logic               we_reg;
    logic [DMEM_AW-1:0] addr_reg;
    logic [31:0]        wdata_reg;
    logic [3:0]         be_reg;
    logic [2:0]         funct3_reg;
    logic [1:0]         off_reg;
    logic [4:0]         rd_reg;
    logic [31:0]        instr_reg;

    logic [31:0]        wb_data_reg;
    logic [4:0]         wb_rd_reg;
    logic               wb_we_reg;
    logic [31:0]        wb_instr_reg;
    logic               exc_reg;

    // ------------------------------------------------------------------
    // Load data extraction, driven by the offset latched with the request
    // ------------------------------------------------------------------
    logic [7:0] rdata_byte [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rbyte
            assign rdata_byte[gi] = dmem_rdata[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;

    always_comb begin
        sel_byte  = rdata_byte[off_reg];
        sel_half  = off_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_data = dmem_rdata;
        case (funct3_reg)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'b0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'b0, sel_half};
            default: load_data = dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Stall: in REQ a granted store frees the pipeline immediately, while
    // a load keeps stalling until the rvalid cycle.
    // ------------------------------------------------------------------
    always_comb begin
        stall_mem = 1'b0;
        case (state_reg)
            ST_IDLE: stall_mem = access_ok;
            ST_REQ:  stall_mem = !(dmem_gnt && we_reg);
            ST_WAIT: stall_mem = !dmem_rvalid;
            default: stall_mem = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM with registered bus and write-back outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            req_reg      <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            be_reg       <= '0;
            funct3_reg   <= '0;
            off_reg      <= '0;
            rd_reg       <= '0;
            instr_reg    <= '0;
            wb_data_reg  <= '0;
            wb_rd_reg    <= '0;
            wb_we_reg    <= 1'b0;
            wb_instr_reg <= '0;
            exc_reg      <= 1'b0;
        end else begin
            // Default: bubble on write-back, no exception
            wb_data_reg  <= '0;
            wb_rd_reg    <= '0;
            wb_we_reg    <= 1'b0;
            wb_instr_reg <= '0;
            exc_reg      <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (access_ok) begin
                        state_reg  <= ST_REQ;
                        req_reg    <= 1'b1;
                        we_reg     <= is_store;
                        addr_reg   <= addr_word;
                        wdata_reg  <= is_store ? wdata_store : 32'b0;
                        be_reg     <= is_store ? be_store : 4'b1111;
                        funct3_reg <= funct3;
                        off_reg    <= addr_lo;
                        rd_reg     <= rd_1;
                        instr_reg  <= instruction_fetched_R1;
                    end else if (is_load || is_store) begin
                        // Misaligned or invalid-funct3 memory op: bubble,
                        // with an exception only for the misaligned case
                        exc_reg <= misaligned;
                    end else begin
                        wb_data_reg  <= data_out_exe;
                        wb_rd_reg    <= rd_1;
                        wb_instr_reg <= instruction_fetched_R1;
                        wb_we_reg    <= ((opcode == R_TYPE) || (opcode == I_TYPE)) &&
                                        (rd_1 != 5'd0);
                    end
                end

                ST_REQ: begin
                    if (dmem_gnt) begin
                        req_reg   <= 1'b0;
                        state_reg <= we_reg ? ST_IDLE : ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (dmem_rvalid) begin
                        wb_data_reg  <= load_data;
                        wb_rd_reg    <= rd_reg;
                        wb_we_reg    <= (rd_reg != 5'd0);
                        wb_instr_reg <= instr_reg;
                        state_reg    <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_req               = req_reg;
    assign dmem_we                = we_reg;
    assign dmem_addr              = addr_reg;
    assign dmem_wdata             = wdata_reg;
    assign dmem_be                = be_reg;
    assign data_out_mem           = wb_data_reg;
    assign rd_2                   = wb_rd_reg;
    assign reg_write_en           = wb_we_reg;
    assign instruction_fetched_R2 = wb_instr_reg;
    assign misaligned_exc         = exc_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Acts as the execute stage (holding its outputs while stall_mem is high)
// and as a byte-addressed data memory on the req/gnt/rvalid bus. Expected
// bus transfers, stall lengths and write-back values come from a
// transaction-level model of the instruction semantics.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    logic        clk_100MHz = 1'b0;
    logic        reset      = 1'b1;
    logic [31:0] instruction_fetched_R1 = '0;
    logic [4:0]  rd_1         = '0;
    logic [31:0] data_out_exe = '0;
    logic [31:0] data_rs2_R1  = '0;
    logic        stall_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt    = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata  = '0;
    logic [31:0] data_out_mem;
    logic [4:0]  rd_2;
    logic        reg_write_en;
    logic [31:0] instruction_fetched_R2;
    logic        misaligned_exc;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [int unsigned];

    always #5 clk_100MHz = ~clk_100MHz;

    mem_access_stage #(.DMEM_AW(32)) dut (
        .clk_100MHz             (clk_100MHz),
        .reset                  (reset),
        .instruction_fetched_R1 (instruction_fetched_R1),
        .rd_1                   (rd_1),
        .data_out_exe           (data_out_exe),
        .data_rs2_R1            (data_rs2_R1),
        .stall_mem              (stall_mem),
        .dmem_req               (dmem_req),
        .dmem_we                (dmem_we),
        .dmem_addr              (dmem_addr),
        .dmem_wdata             (dmem_wdata),
        .dmem_be                (dmem_be),
        .dmem_gnt               (dmem_gnt),
        .dmem_rvalid            (dmem_rvalid),
        .dmem_rdata             (dmem_rdata),
        .data_out_mem           (data_out_mem),
        .rd_2                   (rd_2),
        .reg_write_en           (reg_write_en),
        .instruction_fetched_R2 (instruction_fetched_R2),
        .misaligned_exc         (misaligned_exc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
        end
    endtask

    // Memory contents: written bytes, otherwise a fixed address-derived pattern
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = mem_byte({a[31:2], 2'b00} + 32'(i));
        return w;
    endfunction

    // Little-endian load of 'size' bytes, sign- or zero-extended
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int          size;
        logic [31:0] v;
        size = 1 << f3[1:0];
        v    = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mem_byte(a + 32'(i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
        return v;
    endfunction

    // One instruction through the stage, with a bus slave that grants after
    // gnt_lat idle REQ cycles and returns read data rv_lat cycles after gnt.
    task automatic do_op(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] rs2,
                         input int gnt_lat, input int rv_lat, output int stalls);
        logic [31:0] instr;
        bit          valid_f3, misal, access, is_st;
        int          size, off, exp_stall, req_cnt, grants, since_gnt;
        bit          gnt_seen, done;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_data, exp_instr, exp_addr;
        logic [4:0]  exp_rd;
        logic        exp_we;

        instr        = $urandom;
        instr[14:12] = f3;
        instr[11:7]  = rd;
        instr[6:0]   = op;

        is_st    = (op == OP_STORE);
        valid_f3 = (op == OP_LOAD)  ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) :
                   (op == OP_STORE) ? (f3 <= 2) : 1'b0;
        size     = 1 << f3[1:0];
        off      = int'(addr[1:0]);
        misal    = valid_f3 && ((addr % size) != 0);
        access   = valid_f3 && !misal;
        exp_addr = addr & ~32'd3;

        exp_be = '0;
        exp_wd = '0;
        for (int i = 0; i < 4; i++) begin
            exp_be[i]        = (i >= off) && (i < off + size);
            exp_wd[8*i +: 8] = rs2[8*(i % size) +: 8];
        end
        if (!is_st) exp_be = 4'b1111;

        exp_stall = !access ? 0 : (is_st ? 1 + gnt_lat : gnt_lat + rv_lat + 1);

        exp_data = '0; exp_rd = '0; exp_we = 1'b0; exp_instr = '0;
        if (op != OP_LOAD && op != OP_STORE) begin
            exp_data  = addr;
            exp_rd    = rd;
            exp_instr = instr;
            exp_we    = (op == OP_R || op == OP_I) && (rd != 0);
        end else if (access && !is_st) begin
            exp_data  = model_load(f3, addr);
            exp_rd    = rd;
            exp_instr = instr;
            exp_we    = (rd != 0);
        end

        instruction_fetched_R1 = instr;
        rd_1         = rd;
        data_out_exe = addr;
        data_rs2_R1  = rs2;
        stalls = 0; req_cnt = 0; grants = 0; since_gnt = 0; gnt_seen = 0; done = 0;

        for (int c = 0; c < 60 && !done; c++) begin
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            if (dmem_req) begin
                req_cnt++;
                check_eq({name, "_addr"}, dmem_addr, exp_addr);
                check_eq({name, "_be"}, 32'(dmem_be), 32'(exp_be));
                check_eq({name, "_we"}, 32'(dmem_we), 32'(is_st));
                if (is_st) check_eq({name, "_wdata"}, dmem_wdata, exp_wd);
                if (req_cnt > gnt_lat) dmem_gnt = 1'b1;
                else dmem_rvalid = 1'($urandom_range(0, 1));
            end else if (gnt_seen && !is_st) begin
                since_gnt++;
                if (since_gnt >= rv_lat) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = mem_word(exp_addr);
                end
            end else if (!access) begin
                dmem_rvalid = 1'($urandom_range(0, 1));
            end
            #4;
            if (stall_mem) stalls++;
            else done = 1;
            if (dmem_gnt) begin
                grants++;
                gnt_seen = 1;
                if (is_st)
                    for (int i = 0; i < 4; i++)
                        if (exp_be[i]) mem[exp_addr + 32'(i)] = exp_wd[8*i +: 8];
            end
            @(posedge clk_100MHz);
            #1;
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;

        check_eq({name, "_done"}, 32'(done), 32'd1);
        check_eq({name, "_stalls"}, 32'(stalls), 32'(exp_stall));
        check_eq({name, "_req_cycles"}, 32'(req_cnt), access ? 32'(gnt_lat + 1) : 32'd0);
        check_eq({name, "_grants"}, 32'(grants), 32'(access));
        check_eq({name, "_req_after"}, 32'(dmem_req), 32'd0);
        check_eq({name, "_wb_data"}, data_out_mem, exp_data);
        check_eq({name, "_wb_rd"}, 32'(rd_2), 32'(exp_rd));
        check_eq({name, "_wb_we"}, 32'(reg_write_en), 32'(exp_we));
        check_eq({name, "_wb_instr"}, instruction_fetched_R2, exp_instr);
        check_eq({name, "_exc"}, 32'(misaligned_exc), 32'(misal));
        $display("txn %s op=%02h f3=%0d addr=%08h stalls=%0d wb=%08h", name, op, f3, addr, stalls, data_out_mem);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        int          sel;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  load_f3s [5];

        load_f3s[0] = 3'd0; load_f3s[1] = 3'd1; load_f3s[2] = 3'd2;
        load_f3s[3] = 3'd4; load_f3s[4] = 3'd5;

        // Reset state
        repeat (3) @(posedge clk_100MHz);
        #1;
        check_eq("rst_req", 32'(dmem_req), 32'd0);
        check_eq("rst_data", data_out_mem, 32'd0);
        check_eq("rst_rd", 32'(rd_2), 32'd0);
        check_eq("rst_we", 32'(reg_write_en), 32'd0);
        check_eq("rst_instr", instruction_fetched_R2, 32'd0);
        check_eq("rst_exc", 32'(misaligned_exc), 32'd0);
        reset = 1'b0;

        // ADD pass-through
        do_op("t1_add", OP_R, 3'd0, 5'd5, 32'h0000_0123, 32'd0, 0, 1, st);
        check_eq("t1_data_lit", data_out_mem, 32'h123);
        check_eq("t1_stall_lit", 32'(st), 32'd0);

        // SB with a two-cycle grant delay
        do_op("t2_sb", OP_STORE, 3'd0, 5'd0, 32'h0000_1002, 32'hAABB_CCDD, 2, 1, st);
        check_eq("t2_stall_lit", 32'(st), 32'd3);
        check_eq("t2_mem_lit", 32'(mem_byte(32'h1002)), 32'hDD);

        // Loads from a word holding 0x80FF_1234
        mem[32'h2000] = 8'h34; mem[32'h2001] = 8'h12;
        mem[32'h2002] = 8'hFF; mem[32'h2003] = 8'h80;
        do_op("t3_lb", OP_LOAD, 3'd0, 5'd3, 32'h0000_2003, 32'd0, 0, 3, st);
        check_eq("t3_lb_lit", data_out_mem, 32'hFFFF_FF80);
        do_op("t3_lbu", OP_LOAD, 3'd4, 5'd4, 32'h0000_2003, 32'd0, 0, 3, st);
        check_eq("t3_lbu_lit", data_out_mem, 32'h0000_0080);
        do_op("t3_lhu", OP_LOAD, 3'd5, 5'd6, 32'h0000_2002, 32'd0, 1, 2, st);
        check_eq("t3_lhu_lit", data_out_mem, 32'h0000_80FF);
        do_op("t3_rd0", OP_LOAD, 3'd2, 5'd0, 32'h0000_2000, 32'd0, 0, 1, st);
        check_eq("t3_rd0_we_lit", 32'(reg_write_en), 32'd0);

        // Misaligned LW
        do_op("t4_lw_mis", OP_LOAD, 3'd2, 5'd7, 32'h0000_3002, 32'd0, 0, 1, st);
        check_eq("t4_exc_lit", 32'(misaligned_exc), 32'd1);
        do_op("t4_after", OP_I, 3'd0, 5'd8, 32'h0000_0042, 32'd0, 0, 1, st);

        // Reset while waiting for read data
        instruction_fetched_R1 = {17'd0, 3'd0, 5'd9, OP_LOAD};
        rd_1 = 5'd9; data_out_exe = 32'h0000_2003;
        @(posedge clk_100MHz); #1;
        check_eq("t5_req_on", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(posedge clk_100MHz); #1;
        dmem_gnt = 1'b0;
        reset = 1'b1;
        @(posedge clk_100MHz); #1;
        reset = 1'b0;
        instruction_fetched_R1 = '0; rd_1 = '0; data_out_exe = '0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #4;
        check_eq("t5_req_off", 32'(dmem_req), 32'd0);
        check_eq("t5_stall", 32'(stall_mem), 32'd0);
        @(posedge clk_100MHz); #1;
        dmem_rvalid = 1'b0;
        check_eq("t5_data", data_out_mem, 32'd0);
        check_eq("t5_we", 32'(reg_write_en), 32'd0);
        check_eq("t5_rd", 32'(rd_2), 32'd0);
        check_eq("t5_req_idle", 32'(dmem_req), 32'd0);

        // Back-to-back LW then SW
        do_op("t6_lw", OP_LOAD, 3'd2, 5'd10, 32'h0000_2000, 32'd0, 0, 1, st);
        check_eq("t6_lw_stall_lit", 32'(st), 32'd2);
        do_op("t6_sw", OP_STORE, 3'd2, 5'd0, 32'h0000_2004, 32'h1234_5678, 0, 1, st);
        check_eq("t6_sw_stall_lit", 32'(st), 32'd1);

        // Randomized mix
        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)       op = OP_LOAD;
            else if (sel < 7)  op = OP_STORE;
            else if (sel == 7) op = OP_R;
            else if (sel == 8) op = OP_I;
            else               op = ($urandom_range(0, 1) != 0) ? OP_BR : OP_LUI;
            if (op == OP_LOAD)
                f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(6, 7)) : load_f3s[$urandom_range(0, 4)];
            else if (op == OP_STORE)
                f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            else
                f3 = 3'($urandom_range(0, 7));
            addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 1) != 0) addr = addr + 32'($urandom_range(0, 3));
            do_op("rnd", op, f3, 5'($urandom_range(0, 31)), addr, $urandom,
                  $urandom_range(0, 3), $urandom_range(1, 3), st);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
